// File: rtl/core_ctrl_pkg.sv
// Shared types and output decode for the core run sequencer.
package core_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RESET = 3'd1,
      OPEN  = 3'd2,
      TRIG  = 3'd3,
      RUN   = 3'd4,
      DRAIN = 3'd5,
      DONE  = 3'd6
   } run_state_e;

   // Sticky completion flags; they survive DONE until the next start.
   typedef struct packed {
      logic done;
      logic halted;
      logic timeout;
      logic aborted;
   } run_status_t;

   // Core-facing controls, decoded purely from the state.
   typedef struct packed {
      logic core_rstn;
      logic cg_clk_en;
      logic first_fetch_trigger;
      logic busy;
   } run_ctrl_t;

   function automatic run_ctrl_t state_ctrl(input run_state_e s);
      run_ctrl_t c;
      c = '0;
      case (s)
         RESET:            c.busy = 1'b1;
         OPEN, RUN, DRAIN: c = '{core_rstn: 1'b1, cg_clk_en: 1'b1,
                                 first_fetch_trigger: 1'b0, busy: 1'b1};
         TRIG:             c = '{core_rstn: 1'b1, cg_clk_en: 1'b1,
                                 first_fetch_trigger: 1'b1, busy: 1'b1};
         DONE:             c.core_rstn = 1'b1;  // core state kept for memory dump
         default:          c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/UpCounter.sv
// Saturating up-counter with synchronous clear; used as the RUN watchdog.
module UpCounter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en_i,
   input  logic             clear_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // Count while enabled, hold at all-ones, clear has priority.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rstn) begin
         count_q <= '0;
      end else if (clear_i) begin
         count_q <= '0;
      end else if (en_i && (count_q != '1)) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer for CoreTop: reset release, clock open, first-fetch pulse,
// watchdog supervision, end-of-test detection and clock close.
module core_run_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned RST_CYCLES    = 10,
   parameter int unsigned SETTLE_CYCLES = 10,
   parameter int unsigned DRAIN_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] halt_addr,
   input  logic [CNT_W-1:0]  wd_limit,
   input  logic              wd_kick,
   input  logic              inst_request,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              core_rstn,
   output logic              cg_clk_en,
   output logic              first_fetch_trigger,
   output logic              busy,
   output logic              done,
   output logic              halted,
   output logic              timeout,
   output logic              aborted,
   output logic [2:0]        state_o
);

   // Last in-state count value before each timed state exits.
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] seq_q, seq_d;
   run_status_t      status_q, status_d;
   run_ctrl_t        ctrl_q;
   logic [CNT_W-1:0] wd_cnt;
   logic             state_change;
   logic             halt_hit;
   logic             wd_expire;

   assign state_change = (state_d != state_q);
   assign halt_hit     = inst_request && (inst_addr == halt_addr);
   // A kick in the would-be expiry cycle wins: the counter restarts instead.
   assign wd_expire    = (wd_limit != '0) && !wd_kick &&
                         (wd_cnt == (wd_limit - CNT_W'(1)));

   // Watchdog counts RUN cycles; restarted by a kick or any state entry.
   UpCounter #(.WIDTH(CNT_W)) u_wd (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (state_q == RUN),
      .clear_i (wd_kick || state_change),
      .count_o (wd_cnt)
   );

   // Next-state, sticky-flag and sequence-counter logic.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      status_d = status_q;
      seq_d    = seq_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = RESET;
               status_d = '0;
            end
         end
         RESET: begin
            if (abort) begin
               state_d          = DONE;  // clock never opened, skip drain
               status_d.aborted = 1'b1;
            end else if (seq_q == RST_LAST) begin
               state_d = OPEN;
            end
         end
         OPEN: begin
            if (abort) begin
               state_d          = DRAIN;
               status_d.aborted = 1'b1;
            end else if (seq_q == SETTLE_LAST) begin
               state_d = TRIG;
            end
         end
         TRIG: begin
            // Fetches on this cycle are not halt candidates.
            state_d = RUN;
            if (abort) begin
               state_d          = DRAIN;
               status_d.aborted = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d          = DRAIN;
               status_d.aborted = 1'b1;
            end else if (halt_hit) begin
               state_d         = DRAIN;
               status_d.halted = 1'b1;
            end else if (wd_expire) begin
               state_d          = DRAIN;
               status_d.timeout = 1'b1;
            end
         end
         DRAIN: begin
            if (seq_q == DRAIN_LAST) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d == DONE) begin
         status_d.done = 1'b1;
      end

      if (state_change) begin
         seq_d = '0;
      end else if ((state_q == RESET) || (state_q == OPEN) || (state_q == DRAIN)) begin
         seq_d = seq_q + CNT_W'(1);
      end
   end

   // State, flags and registered Moore outputs; outputs track the new state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         seq_q    <= '0;
         status_q <= '0;
         ctrl_q   <= '0;
      end else begin
         state_q  <= state_d;
         seq_q    <= seq_d;
         status_q <= status_d;
         ctrl_q   <= state_ctrl(state_d);
      end
   end

   assign core_rstn           = ctrl_q.core_rstn;
   assign cg_clk_en           = ctrl_q.cg_clk_en;
   assign first_fetch_trigger = ctrl_q.first_fetch_trigger;
   assign busy                = ctrl_q.busy;
   assign done                = status_q.done;
   assign halted              = status_q.halted;
   assign timeout             = status_q.timeout;
   assign aborted             = status_q.aborted;
   assign state_o             = state_q;

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Synthesizable run sequencer for the CoreTop instance. Replaces the bench-driven bring-up: core reset release, clock-gate open, first-fetch pulse, watchdog supervision, end-of-test detection, clock close.
- Sits between the system-level start/status interface and the core's rstn, ClockGate enable and first_fetch_trigger.
- Monitors the InstructionFetch request/address pair.

Parameters:
- ADDR_W, 32: width of inst_addr and halt_addr.
- CNT_W, 16: width of the sequence and watchdog counters.
- RST_CYCLES, 10: cycles core_rstn is held low after start; range 1..2^CNT_W-1.
- SETTLE_CYCLES, 10: cycles the gated clock runs before the first-fetch pulse; range 1..2^CNT_W-1.
- DRAIN_CYCLES, 4: cycles the gated clock stays open after halt, timeout or abort; range 1..2^CNT_W-1.

Ports:
- clk  in  1  free-running clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- abort  in  1  forced stop request.
- halt_addr  in  ADDR_W  end-of-test fetch address; static while busy.
- wd_limit  in  CNT_W  watchdog limit in RUN cycles; 0 disables the watchdog.
- wd_kick  in  1  watchdog clear.
- inst_request  in  1  core fetch request.
- inst_addr  in  ADDR_W  core fetch address.
- core_rstn  out  1  core reset, active low.
- cg_clk_en  out  1  ClockGate enable.
- first_fetch_trigger  out  1  one-cycle first-fetch pulse.
- busy  out  1  high in any state except IDLE and DONE.
- done  out  1  sticky run-complete flag.
- halted  out  1  sticky: run ended on halt_addr.
- timeout  out  1  sticky: run ended on watchdog expiry.
- aborted  out  1  sticky: run ended on abort.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Reset: rstn low asynchronously forces IDLE. All outputs 0, including core_rstn=0. Both counters cleared.
- Outputs: every output is registered and is a pure function of the state (Moore). The sticky flags are separate flops.
- IDLE: core_rstn=0, cg_clk_en=0. On start=1 go to RESET; clear done, halted, timeout, aborted.
- RESET: core_rstn=0. Stay RST_CYCLES cycles, then go to OPEN.
- OPEN: core_rstn=1, cg_clk_en=1. Stay SETTLE_CYCLES cycles, then go to TRIG.
- TRIG: exactly 1 cycle; first_fetch_trigger=1, cg_clk_en=1. Then go to RUN; the watchdog counter is 0 on entry.
- RUN: cg_clk_en=1. The watchdog counter increments each cycle and is cleared to 0 by wd_kick.
  - Halt: inst_request=1 and inst_addr==halt_addr → go to DRAIN; halted=1.
  - Expiry: wd_limit!=0, counter==wd_limit-1 and wd_kick=0 → go to DRAIN; timeout=1.
- DRAIN: cg_clk_en=1, core_rstn=1. Stay DRAIN_CYCLES cycles, then go to DONE.
- DONE: cg_clk_en=0, core_rstn=1 (core state kept for memory dump), done=1. On start=1 go to RESET and clear all sticky flags in the same cycle.
- Latency: start sampled at cycle T gives:
  - RESET at T+1;
  - OPEN at T+1+RST_CYCLES;
  - TRIG at T+1+RST_CYCLES+SETTLE_CYCLES.
- Priority in RUN: abort > halt > expiry. Consequences:
  - halt and expiry in the same cycle → halted only;
  - wd_kick in the expiry cycle prevents expiry.
- Abort:
  - In RESET → go directly to DONE (clock never opened), aborted=1.
  - In OPEN, TRIG or RUN → go to DRAIN, aborted=1.
  - Ignored in DRAIN, IDLE and DONE.
- Start while busy is ignored.
- Fetch requests outside RUN are ignored for halt detection.
- A halt_addr match on the TRIG cycle does not count.
- Watchdog counter saturates at 2^CNT_W-1 when wd_limit=0.
- Counters reset to 0 on every state entry.
- Asynchronous reset mid-run: immediate return to IDLE, clock gate closed, core held in reset.

Decomposition:
- core_ctrl_pkg holds:
  - typedef enum logic [2:0] run_state_e: IDLE=0, RESET=1, OPEN=2, TRIG=3, RUN=4, DRAIN=5, DONE=6;
  - typedef run_status_t, a packed struct of done, halted, timeout and aborted.
- The watchdog reuses the existing UpCounter with WIDTH=CNT_W. en = RUN; clear = wd_kick or state entry. The limit compare lives in core_run_ctrl.
- The sequence counter is inline.

Test Plan:
- Nominal run: default parameters, halt_addr=0x20, start at cycle 0. Required response:
  - core_rstn rises at cycle 11;
  - first_fetch_trigger is high only at cycle 21;
  - fetch of 0x20 in RUN → DRAIN for 4 cycles, then done=1, halted=1, cg_clk_en=0.
- Watchdog expiry: wd_limit=50, no kick, no halt → timeout=1 exactly 50 cycles after RUN entry, then done after 4 drain cycles.
- Kick in the expiry cycle: wd_limit=50, wd_kick pulsed on RUN cycle 49 → no timeout. Expiry occurs 50 cycles after the kick.
- Simultaneous events:
  - halt and expiry in the same cycle → halted=1, timeout=0;
  - abort in that same cycle → aborted=1 only.
- Abort in RESET at cycle 5 → DONE next cycle with aborted=1; cg_clk_en never asserted.
- Restart and async reset:
  - start in DONE → all flags clear, sequence repeats with identical timing;
  - rstn low mid-RUN → all outputs 0 immediately;
  - start while busy is ignored.
